// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: pipeline occupancy type, perf counter width
// default and the packed bundles carried between pipeline stages.
package cpu_types_pkg;

  typedef logic [1:0] pipe_occ_t;

  localparam int PIPE_CNT_W_DEF = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } idex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } exmm_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
  } mmwb_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for pipeline perf stats.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Reset and clear win over counting; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register between two CPU stages with valid/ready handshake,
// flush, optional skid entry (registered in_ready) and starve/stall counters.
module pipe_stage_reg
  import cpu_types_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter bit               SKID      = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = PIPE_CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             cnt_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output pipe_occ_t        occupancy,
  output logic [CNT_W-1:0] starve_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             valid_m;
  logic [WIDTH-1:0] data_m;
  logic             valid_s;
  logic             in_fire;
  logic             out_fire;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_valid = valid_m;
  assign out_data  = data_m;
  assign occupancy = {1'b0, valid_m} + {1'b0, valid_s};

  if (SKID == 1'b0) begin : g_single

    assign valid_s  = 1'b0;
    assign in_ready = ~valid_m | out_ready;

    // Single main register: load on accept, drop valid once consumed.
    always_ff @(posedge CLK) begin
      if (RST || flush) begin
        valid_m <= 1'b0;
        data_m  <= RESET_VAL;
      end else if (in_fire) begin
        valid_m <= 1'b1;
        data_m  <= in_data;
      end else if (out_fire) begin
        valid_m <= 1'b0;
      end
    end

  end else begin : g_skid

    logic [WIDTH-1:0] data_s;
    logic             m_free;

    assign in_ready = ~valid_s;
    assign m_free   = ~valid_m | out_ready;

    // Main plus skid entry: the skid always refills main first so order holds.
    always_ff @(posedge CLK) begin
      if (RST || flush) begin
        valid_m <= 1'b0;
        data_m  <= RESET_VAL;
        valid_s <= 1'b0;
        data_s  <= RESET_VAL;
      end else if (m_free) begin
        if (valid_s) begin
          valid_m <= 1'b1;
          data_m  <= data_s;
          valid_s <= 1'b0;
        end else if (in_fire) begin
          valid_m <= 1'b1;
          data_m  <= in_data;
        end else begin
          valid_m <= 1'b0;
        end
      end else if (in_fire) begin
        valid_s <= 1'b1;
        data_s  <= in_data;
      end
    end

  end

  sat_counter #(.CNT_W(CNT_W)) u_starve_cnt (
    .clk (CLK),
    .rst (RST),
    .inc (out_ready & ~out_valid),
    .clr (cnt_clr),
    .cnt (starve_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (CLK),
    .rst (RST),
    .inc (out_valid & ~out_ready),
    .clr (cnt_clr),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: one single-register and one skid
// instance sharing clock, reset, flush and counter clear, each with its own
// scoreboard queue fed on accept and drained on consume.
module tb_pipe_stage_reg;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        RST;
  logic        flush;
  logic        cnt_clr;

  logic        in_valid0, in_ready0, out_valid0, out_ready0;
  logic [31:0] in_data0, out_data0;
  pipe_occ_t   occ0;
  logic [3:0]  starve0, stall0;

  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [31:0] in_data1, out_data1;
  pipe_occ_t   occ1;
  logic [3:0]  starve1, stall1;

  int          total_checks = 0;
  int          fail_count   = 0;
  logic [31:0] sb0[$];
  logic [31:0] sb1[$];

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b0), .CNT_W(4)) u_dut0 (
    .CLK(CLK), .RST(RST), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .occupancy(occ0), .starve_cnt(starve0), .stall_cnt(stall0)
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .CNT_W(4)) u_dut1 (
    .CLK(CLK), .RST(RST), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .occupancy(occ1), .starve_cnt(starve1), .stall_cnt(stall1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of handshake inputs on both instances, then step past the edge.
  task automatic applyStimulus(input logic iv0, input logic [31:0] id0, input logic or0,
                               input logic iv1, input logic [31:0] id1, input logic or1);
    in_valid0  = iv0;
    in_data0   = id0;
    out_ready0 = or0;
    in_valid1  = iv1;
    in_data1   = id1;
    out_ready1 = or1;
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard for the single-register instance, sampled mid-cycle.
  always @(negedge CLK) begin
    if (RST) begin
      sb0.delete();
    end else begin
      if (out_valid0 && out_ready0) begin
        if (sb0.size() == 0) checkOutput("sb0_unexpected", 32'(sb0.size()), 32'd1);
        else checkOutput("sb0_order", out_data0, sb0.pop_front());
      end
      if (flush) sb0.delete();
      else if (in_valid0 && in_ready0) sb0.push_back(in_data0);
    end
  end

  // Scoreboard for the skid instance, sampled mid-cycle.
  always @(negedge CLK) begin
    if (RST) begin
      sb1.delete();
    end else begin
      if (out_valid1 && out_ready1) begin
        if (sb1.size() == 0) checkOutput("sb1_unexpected", 32'(sb1.size()), 32'd1);
        else checkOutput("sb1_order", out_data1, sb1.pop_front());
      end
      if (flush) sb1.delete();
      else if (in_valid1 && in_ready1) sb1.push_back(in_data1);
    end
  end

  initial begin
    RST     = 1'b1;
    flush   = 1'b0;
    cnt_clr = 1'b0;

    // Reset for two cycles with a valid bundle offered.
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    checkOutput("rst_valid0", 32'(out_valid0), 32'd0);
    checkOutput("rst_data0", out_data0, 32'd0);
    checkOutput("rst_occ0", 32'(occ0), 32'd0);
    checkOutput("rst_starve0", 32'(starve0), 32'd0);
    checkOutput("rst_stall0", 32'(stall0), 32'd0);
    checkOutput("rst_valid1", 32'(out_valid1), 32'd0);
    checkOutput("rst_data1", out_data1, 32'd0);
    checkOutput("rst_occ1", 32'(occ1), 32'd0);
    checkOutput("rst_starve1", 32'(starve1), 32'd0);
    checkOutput("rst_stall1", 32'(stall1), 32'd0);
    RST = 1'b0;

    // Streaming on both instances: 1 cycle latency, no bubbles.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b1, 1'b1, 32'(i), 1'b1);
      checkOutput("stream_valid0", 32'(out_valid0), 32'd1);
      checkOutput("stream_data0", out_data0, 32'(i));
      checkOutput("stream_valid1", 32'(out_valid1), 32'd1);
      checkOutput("stream_data1", out_data1, 32'(i));
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("stream_end0", 32'(out_valid0), 32'd0);
    checkOutput("stream_end1", 32'(out_valid1), 32'd0);

    // Backpressure on the skid instance.
    cnt_clr = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'hA, 1'b1);
    cnt_clr = 1'b0;
    checkOutput("bp_hold_a", out_data1, 32'hA);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'hB, 1'b0);
    checkOutput("bp_ready_low", 32'(in_ready1), 32'd0);
    checkOutput("bp_occ2", 32'(occ1), 32'd2);
    checkOutput("bp_stable1", out_data1, 32'hA);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'hC, 1'b0);
    checkOutput("bp_stable2", out_data1, 32'hA);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'hC, 1'b0);
    checkOutput("bp_stable3", out_data1, 32'hA);
    checkOutput("bp_stall_cnt", 32'(stall1), 32'd3);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'hC, 1'b1);
    checkOutput("bp_drain_b", out_data1, 32'hB);
    checkOutput("bp_ready_back", 32'(in_ready1), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'hC, 1'b1);
    checkOutput("bp_drain_c", out_data1, 32'hC);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("bp_empty", 32'(out_valid1), 32'd0);
    checkOutput("bp_stall_final", 32'(stall1), 32'd3);

    // Flush: skid instance full, single instance consuming while accepting.
    applyStimulus(1'b1, 32'h66, 1'b0, 1'b1, 32'h11, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h22, 1'b0);
    checkOutput("fl_occ_before", 32'(occ1), 32'd2);
    flush = 1'b1;
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b1, 32'h55, 1'b0);
    flush = 1'b0;
    checkOutput("fl_valid0", 32'(out_valid0), 32'd0);
    checkOutput("fl_data0", out_data0, 32'd0);
    checkOutput("fl_valid1", 32'(out_valid1), 32'd0);
    checkOutput("fl_occ1", 32'(occ1), 32'd0);
    checkOutput("fl_data1", out_data1, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput("fl_quiet0", 32'(out_valid0), 32'd0);
      checkOutput("fl_quiet1", 32'(out_valid1), 32'd0);
    end

    // Counter saturation with 4-bit counters.
    cnt_clr = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    cnt_clr = 1'b0;
    checkOutput("sat_cleared", 32'(starve1), 32'd0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("sat_starve1", 32'(starve1), 32'd15);
    checkOutput("sat_starve0", 32'(starve0), 32'd15);
    checkOutput("sat_stall1", 32'(stall1), 32'd0);
    cnt_clr = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    cnt_clr = 1'b0;
    checkOutput("clr_wins1", 32'(starve1), 32'd0);
    checkOutput("clr_wins0", 32'(starve0), 32'd0);

    // Reset while the skid instance is full and stalled.
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h31, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h32, 1'b0);
    checkOutput("mr_occ_before", 32'(occ1), 32'd2);
    RST = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    RST = 1'b0;
    checkOutput("mr_occ", 32'(occ1), 32'd0);
    checkOutput("mr_valid", 32'(out_valid1), 32'd0);
    checkOutput("mr_stall", 32'(stall1), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h7, 1'b1);
    checkOutput("mr_first_valid", 32'(out_valid1), 32'd1);
    checkOutput("mr_first_data", out_data1, 32'h7);
    checkOutput("mr_first_occ", 32'(occ1), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("mr_alone", 32'(out_valid1), 32'd0);

    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("sb0_drained", 32'(sb0.size()), 32'd0);
    checkOutput("sb1_drained", 32'(sb1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", total_checks, fail_count);
    $finish;
  end

endmodule
